instr_loader: RTL and testbench

//  Writer side of the CPU's instruction path: receives a program as a byte stream (valid/ready),

---
 rtl/loader_pkg.sv | 26 ++
 rtl/byte_packer.sv | 40 ++++
 rtl/instr_loader.sv | 149 ++++++++++++++
 tb/tb_instr_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
//   state_t    : loader FSM states
//   LEN_BYTES  : bytes in the little-endian length field
//   CHK_BYTES  : bytes in the little-endian checksum field
//   WORD_BYTES : bytes per instruction word
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned CHK_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  // True when a received length field describes a loadable image.
  function automatic logic len_ok(input logic [31:0] n, input logic [31:0] depth);
    return (n != 32'd0) && (n <= depth);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian 32-bit word from a byte stream.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart assembly at byte 0 (discards a partial word)
//   byte_valid  : a byte is accepted this cycle
//   byte_in     : the accepted byte
//   word_valid  : high in the cycle the 4th byte is accepted (combinational)
//   word        : assembled word, valid while word_valid is high
//   byte_cnt    : bytes of the current word already held (0..3)
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  // The word is presented in the same cycle as its last byte so the
  // controller can register its decision on that edge (one-cycle latency).
  assign word_valid = byte_valid && (cnt == 2'd3);
  assign word       = {byte_in, acc};
  assign byte_cnt   = cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 2'd0;
      acc <= 24'd0;
    end else if (byte_valid) begin
      // First byte ends up in [7:0]: shift new bytes in from the top.
      acc <= {byte_in, acc[23:8]};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Writer side of the instruction path. Receives a framed program image
// (length, data words, checksum; all little-endian) over a valid/ready byte
// link and writes the words into instruction memory from address 0 upward.
// The CPU is held in reset until a complete, checksum-verified image is in.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a load (honoured in IDLE, DONE, ERR only)
//   in_valid    : byte present on in_byte
//   in_byte     : stream byte
//   in_ready    : loader accepts a byte this cycle
//   mem_we      : memory write strobe, one cycle per word
//   mem_addr    : word address of the write
//   mem_wdata   : word to write
//   cpu_hold    : keep CPU in reset (low only in DONE)
//   done        : image loaded and checksum matched (sticky)
//   error       : bad length or checksum mismatch (sticky)
//   word_count  : words written in the current/last load
//   dbg_state   : current FSM state
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state, never on in_valid; a source that
// sees in_ready low keeps the same byte on in_byte until it transfers.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output state_t            dbg_state
);

  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [31:0]     csum;

  logic            byte_acc;
  logic            start_ok;
  logic            word_valid;
  logic [31:0]     word;
  logic [1:0]      byte_cnt;

  assign in_ready  = (state == LEN) || (state == DATA) || (state == CHK);
  assign byte_acc  = in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign dbg_state = state;

  // Field boundaries always coincide with the packer wrapping to byte 0,
  // so the only extra clear needed is on entry to LEN.
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (byte_acc),
    .byte_in    (in_byte),
    .word_valid (word_valid),
    .word       (word),
    .byte_cnt   (byte_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      csum       <= 32'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start_ok) begin
            state      <= LEN;
            len_q      <= '0;
            csum       <= 32'd0;
            mem_addr   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
          end
        end

        LEN: begin
          if (word_valid) begin
            if (len_ok(word, DEPTH32)) begin
              state <= DATA;
              len_q <= word[ADDR_W:0];
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end

        DATA: begin
          if (word_valid) begin
            // word_count doubles as the write index; it steps together
            // with the strobe it accounts for.
            mem_we     <= 1'b1;
            mem_addr   <= word_count[ADDR_W-1:0];
            mem_wdata  <= word;
            csum       <= csum + word;
            word_count <= word_count + 1'b1;
            if (word_count + 1'b1 == len_q) begin
              state <= CHK;
            end
          end
        end

        CHK: begin
          if (word_valid) begin
            if (word == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed frames driven over the
// byte link, a frame-level model producing the expected write sequence and
// final status, and a per-cycle compare process on the memory write port.
module tb_instr_loader;
  import loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int W     = AW + 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;
  state_t        dbg_state;

  instr_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [31:0]   frame_words[$];
  logic [31:0]   dut_mem [0:DEPTH-1];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            we_count = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compare process: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      dut_mem[mem_addr] = mem_wdata;
      we_count++;
      last_addr = mem_addr;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write", {mem_addr, mem_wdata}, 64'(e));
        check("wc_at_write", 64'(word_count), 64'(e[W-1:32]) + 64'd1);
      end
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 64; t++) begin
      if (in_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_checks++;
    $display("FAIL send_byte_timeout: got in_ready=0 for 64 cycles expected 1 (byte %0h)", b);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'd0);
    check({tag, "_mem_we"},     64'(mem_we),     64'd0);
    check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
    check({tag, "_mem_wdata"},  64'(mem_wdata),  64'd0);
    check({tag, "_cpu_hold"},   64'(cpu_hold),   64'd1);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_error"},      64'(error),      64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
    check({tag, "_state"},      64'(dbg_state),  64'(IDLE));
  endtask

  // Model + driver for one complete frame built from frame_words.
  task automatic run_frame(input string tag, input logic [31:0] len, input logic [31:0] chk_xor,
                           input int gap, input int mid_start_at, input bit pre_hold,
                           output logic [31:0] sum);
    bit          ok;
    bit          exp_done;
    logic [31:0] chk;
    int          exp_wc;
    sum = 32'd0;
    ok  = (len >= 32'd1) && (len <= 32'(DEPTH));
    if (ok) begin
      for (int i = 0; i < int'(len); i++) begin
        exp_q.push_back({AW'(i), frame_words[i]});
        sum = sum + frame_words[i];
      end
    end
    chk      = sum ^ chk_xor;
    exp_done = ok && (chk_xor == 32'd0);
    exp_wc   = ok ? int'(len) : 0;
    we_count = 0;

    if (pre_hold) begin
      // Byte offered while the loader is idle must wait, not be lost.
      in_valid = 1'b1;
      in_byte  = len[7:0];
      repeat (3) @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(len, gap);
    if (ok) begin
      for (int i = 0; i < int'(len); i++) begin
        if (i == mid_start_at) start = 1'b1;
        send_word(frame_words[i], gap);
        start = 1'b0;
      end
      send_word(chk, gap);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    check({tag, "_done"},       64'(done),       64'(exp_done));
    check({tag, "_error"},      64'(error),      64'(!exp_done));
    check({tag, "_cpu_hold"},   64'(cpu_hold),   64'(!exp_done));
    check({tag, "_word_count"}, 64'(word_count), 64'(exp_wc));
    check({tag, "_we_count"},   64'(we_count),   64'(exp_wc));
    check({tag, "_pending"},    64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_t1_words();
    frame_words.delete();
    frame_words.push_back(32'h0000_0013);
    frame_words.push_back(32'h0010_0093);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] sum;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1. basic two-word image
    set_t1_words();
    run_frame("t1", 32'd2, 32'd0, 0, -1, 1'b0, sum);
    check("t1_sum_model", 64'(sum), 64'h0010_00A6);
    check("t1_mem0", 64'(dut_mem[0]), 64'h0000_0013);
    check("t1_mem1", 64'(dut_mem[1]), 64'h0010_0093);

    // 2. checksum byte 0 A6 -> A7
    run_frame("t2", 32'd2, 32'h0000_0001, 0, -1, 1'b0, sum);

    // 3. illegal lengths: no writes
    frame_words.delete();
    run_frame("t3_len0",   32'd0,           32'd0, 0, -1, 1'b0, sum);
    run_frame("t3_lenbig", 32'(DEPTH + 1),  32'd0, 0, -1, 1'b0, sum);

    // 4. randomly gapped valid, first byte held across in_ready=0
    for (int i = 0; i < DEPTH; i++) dut_mem[i] = 32'hDEAD_BEEF;
    set_t1_words();
    run_frame("t4", 32'd2, 32'd0, 3, -1, 1'b1, sum);
    check("t4_mem0", 64'(dut_mem[0]), 64'h0000_0013);
    check("t4_mem1", 64'(dut_mem[1]), 64'h0010_0093);

    // 5. reset after 6 data bytes, then a clean reload
    exp_q.push_back({AW'(0), 32'h0000_0013});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("t5_rst");
    rst = 1'b0;
    check("t5_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    run_frame("t5_reload", 32'd2, 32'd0, 0, -1, 1'b0, sum);

    // 6. full-depth image, start pulsed mid-DATA
    frame_words.delete();
    for (int i = 0; i < DEPTH; i++) frame_words.push_back(32'(i));
    run_frame("t6", 32'(DEPTH), 32'd0, 0, 100, 1'b0, sum);
    check("t6_sum_model", 64'(sum), 64'h0000_7F80);
    check("t6_last_addr", 64'(last_addr), 64'(DEPTH - 1));
    check("t6_mem_last",  64'(dut_mem[DEPTH-1]), 64'(DEPTH - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
